// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S stereo DAC transmitter.
// Mono 32-bit samples arrive over valid/ready into a 4-entry FIFO. Each
// 64-bclk frame pops one sample. The sample is truncated to its top 24 bits
// and sent MSB first on both the left and right channels. There is a one-bclk
// delay after each lrclk edge, and the rest of each slot is zero padded. All
// pin changes are aligned to the bclk falling edge.
module audio_i2s_tx #(
  parameter int unsigned CLK_DIV = 16  // clk cycles per bclk half-period, >= 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sample,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underflow,
  output logic [2:0]  fifo_level
);

  localparam int unsigned          DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam int unsigned          DEPTH    = 4;
  localparam logic [5:0]           SLOT_END = 6'd63;
  localparam logic [2:0]           LVL_FULL = 3'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q,    bclk_d;
  logic [5:0]       slot_q,    slot_d;
  logic             lrclk_q,   lrclk_d;
  logic             sdata_q,   sdata_d;
  logic             uflow_q,   uflow_d;
  logic [23:0]      word_q,    word_d;

  logic [31:0]      mem_q [DEPTH];
  logic [1:0]       wr_ptr_q,  wr_ptr_d;
  logic [1:0]       rd_ptr_q,  rd_ptr_d;
  logic [2:0]       level_q,   level_d;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic div_wrap;     // last clk of a bclk half-period
  logic fall_evt;     // bclk is about to fall: slot logic advances here
  logic frame_start;  // fall event that enters slot 0
  logic push;
  logic pop;

  assign div_wrap    = (div_cnt_q == DIV_MAX);
  assign fall_evt    = div_wrap && bclk_q;
  assign frame_start = fall_evt && (slot_q == SLOT_END);

  // The pop decision uses the occupancy before any same-cycle push. A sample
  // pushed on the frame-start cycle into an empty FIFO waits for the next frame.
  assign sample_ready = !reset && (level_q < LVL_FULL);
  assign push         = sample_valid && sample_ready;
  assign pop          = frame_start && (level_q != 3'd0);

  // Serial bit driven during slot k for the frame word w. The left word is in
  // slots 1..24 and the right word is in slots 33..56. All other slots are zero.
  function automatic logic slot_bit(input logic [5:0] k, input logic [23:0] w);
    logic b;
    b = 1'b0;
    if ((k >= 6'd1) && (k <= 6'd24)) begin
      b = w[5'(6'd24 - k)];
    end else if ((k >= 6'd33) && (k <= 6'd56)) begin
      b = w[5'(6'd56 - k)];
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic for divider, slot sequencer, frame word and FIFO pointers
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch; a missing default in
    // always_comb infers a latch.
    div_cnt_d = div_cnt_q + DIV_W'(1);
    bclk_d    = bclk_q;
    slot_d    = slot_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    uflow_d   = 1'b0;
    word_d    = word_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;

    if (div_wrap) begin
      div_cnt_d = '0;
      bclk_d    = !bclk_q;
    end

    if (fall_evt) begin
      slot_d  = slot_q + 6'd1;
      lrclk_d = slot_d[5];                   // slots 32..63 are the right channel
      sdata_d = slot_bit(slot_d, word_q);    // slot 0 is zero, so the old word is harmless
    end

    if (frame_start) begin
      if (pop) begin
        word_d = mem_q[rd_ptr_q][31:8];
      end else begin
        word_d  = 24'h0;
        uflow_d = 1'b1;
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers with synchronous reset; a reset mid-frame restarts cleanly
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so that every register
    // samples the values from before the edge, independent of statement order.
    if (reset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      slot_q    <= SLOT_END;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      uflow_q   <= 1'b0;
      word_q    <= 24'h0;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      level_q   <= 3'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      slot_q    <= slot_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      uflow_q   <= uflow_d;
      word_q    <= word_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

  // FIFO storage: write the accepted sample at the write pointer
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers and level define which
    // entries are valid, so stale data is never read.
    if (push) begin
      mem_q[wr_ptr_q] <= sample;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from registers, so the pins are glitch free
  // ---------------------------------------------------------------------------
  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign underflow  = uflow_q;
  assign fifo_level = level_q;

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Serial audio transmitter that consumes signed 32-bit mono samples from the oscillator/mixer datapath and drives a standard I2S stereo DAC interface (bclk, lrclk, sdata). Samples are taken over a valid/ready handshake into a 4-entry FIFO. Each sample is truncated to 24 bits and sent identically on the left and right channels. It sits at the output of the synthesizer datapath and is the only block that touches the DAC pins.

## Interface

- CLK_DIV, 16, clk cycles per bclk half-period (≥2); bclk = f_clk/(2·CLK_DIV); frame = 64 bclk periods
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- sample  in  32  signed sample from the datapath (two's complement)
- sample_valid  in  1  sample presented this cycle
- sample_ready  out  1  FIFO can accept; transfer occurs when sample_valid && sample_ready on a rising clk edge
- bclk  out  1  I2S bit clock
- lrclk  out  1  I2S word select; 0 = left, 1 = right
- sdata  out  1  I2S serial data, MSB first
- underflow  out  1  one-cycle pulse when a frame starts with the FIFO empty
- fifo_level  out  3  FIFO occupancy, 0..4

## Operation

- **Divider:**
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - On a wrap cycle, bclk toggles.
  - A "fall event" is a wrap cycle with bclk==1. All slot logic updates on a fall event, so bclk, lrclk and sdata change on the same clk edge.
- **Slot counter:**
  - 6 bits, wraps 63→0, increments on each fall event. Reset value is 63, so the first fall event is slot 0.
- **Frame load (slot 0 fall event):**
  - If the FIFO level *before* any same-cycle push is >0: pop, and word = sample[31:8].
  - Otherwise: word = 24'h0 and underflow pulses for that one cycle.
  - The word is held for the whole frame.
- **Slot k mapping (driven from the fall event of slot k):**
  - lrclk = (k ≥ 32).
  - sdata by slot:
    - k=0: 0
    - k=1..24: word[24-k] (left, MSB first)
    - k=25..32: 0
    - k=33..56: word[56-k] (right)
    - k=57..63: 0
  - This gives the I2S one-bclk delay after the lrclk edge, with zero padding.
- **FIFO:**
  - 4 deep, first-in first-out.
  - sample_ready = !reset && fifo_level<4.
  - Push and pop in the same cycle: both happen, level unchanged.
  - Push while full cannot occur, because ready is low.
  - Push into an empty FIFO on a slot-0 fall event: the pop is refused (underflow, zero frame) and the pushed sample is stored, so level becomes 1.
- **Overflow of input:** none possible. The source must hold sample_valid until ready.

## Timing

- **Reset values:**
  - bclk=0, lrclk=0, sdata=0, underflow=0, fifo_level=0.
  - sample_ready=0 while reset is high, and 1 on the first cycle after reset deasserts.
  - Internal state: div_cnt=0, slot=63, FIFO empty, word=0.
- **Reset mid-frame:** aborts immediately. All outputs return to reset values on the next edge, FIFO contents are discarded, and the frame restarts from scratch.
- **After reset release at edge T:**
  - bclk rises at T+CLK_DIV.
  - The first fall event (slot 0) is at T+2·CLK_DIV.
- **Bit period:** sdata is stable for 2·CLK_DIV cycles, from bclk fall to the next bclk fall. The DAC samples on bclk rise, mid-bit.
- **Frame length:** 128·CLK_DIV clk cycles (2048 at default, i.e. 48.83 kHz at 100 MHz).
- **Sample latency:** a sample accepted with an empty FIFO before a slot-0 fall event has its MSB on sdata exactly 2·CLK_DIV cycles after that event (slot 1).
- **fifo_level timing:** updates on the edge after a push or pop.
- **sample_ready timing:** combinational from level; rises the cycle after a pop from full.

## Test plan

1. **Reset:**
   - Stimulus: hold reset 3 cycles, then release.
   - Response: all outputs 0 during reset; sample_ready=1 on the first cycle after release; first bclk rise 16 cycles after release, first fall at 32 cycles.
2. **Single sample:**
   - Stimulus: push 32'h12345678 before the first slot 0.
   - Response: slots 1..24 carry 24'h123456 MSB first with lrclk=0 from slot 0; slots 25..32 are 0; lrclk=1 from slot 32; slots 33..56 repeat 24'h123456; next frame underflows.
3. **Negative value:**
   - Stimulus: push 32'hFFFFFF00 (-256).
   - Response: both channels carry 24'hFFFFFF, and the MSB at slot 1 is 1.
4. **Underflow:**
   - Stimulus: no samples for 3 frames.
   - Response: sdata is 0 throughout; underflow pulses exactly one cycle at each slot-0 fall event (3 pulses, 2048 cycles apart).
5. **Backpressure:**
   - Stimulus: hold sample_valid with values 1..5 back-to-back after reset.
   - Response: 4 accepted, fifo_level=4, sample_ready=0 and value 5 stalled. At slot 0, value 1 is popped, level goes to 3, and value 5 is accepted next cycle. Frames output 1,2,3,4,5 in order.
6. **Simultaneous push/pop at empty:**
   - Stimulus: assert a push on exactly the slot-0 fall-event cycle with the FIFO empty.
   - Response: underflow=1, zero frame, fifo_level=1 afterwards, and that sample is sent in the following frame.
